pio_loader: RTL and testbench
=============================

Name: pio_loader

Overview:
- Parametrised boot sequencer for a pio instance. It streams a program image, then a list of configuration entries, from two external synchronous ROMs into the pio's action/index/din/mindex command port.
- Lengths are run-time inputs, and any state machine can be addressed per entry.
- Supports auto-start after reset, re-load on request, optional zero-fill of unused instruction slots, and busy/done/err status for the top level.

Parameters:
- PROG_DEPTH, 32, instruction slots in the pio; power of two, ≤32.
- CONF_DEPTH, 32, maximum number of configuration entries.
- NUM_SM, 4, number of state machines; power of two.
- LOAD_ACTION, 1, action code used for instruction writes.
- AUTO_START, 1, if 1, a load begins automatically after reset deasserts.
- CLEAR_UNUSED, 1, if 1, slots prog_len..PROG_DEPTH-1 are written with 16'h0000.
- Derived: PAW = clog2(PROG_DEPTH), CAW = clog2(CONF_DEPTH), MW = max(1, clog2(NUM_SM)).

Ports:
- clk_25mhz  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle load request
- prog_len  in  PAW+1  number of instructions to load (0..PROG_DEPTH)
- conf_len  in  CAW+1  number of config entries (0..CONF_DEPTH)
- prog_addr  out  PAW  program ROM address
- prog_data  in  16  program ROM data, valid one cycle after prog_addr
- conf_addr  out  CAW  config ROM address
- conf_data  in  40  config entry {mindex[39:38], action[37:32], data[31:0]}, valid one cycle after conf_addr
- action  out  6  pio command; nonzero for exactly one cycle per write
- index  out  5  instruction index for program writes
- din  out  32  pio data
- mindex  out  2  target state machine
- busy  out  1  load in progress
- done  out  1  sticky; last load completed
- err  out  1  sticky; last request rejected

Behaviour:
- Reset values: action=0, index=0, din=0, mindex=0, prog_addr=0, conf_addr=0, busy=0, done=0, err=0, FSM=IDLE.
- Reset mid-load aborts immediately; no further writes are issued. If AUTO_START=1, a fresh load starts on the first cycle after reset deasserts.
- Launch: a load launches from IDLE or DONE on start=1, or on the auto-start trigger. On launch:
  - prog_len and conf_len are captured into internal registers; later input changes are ignored.
  - done and err are cleared.
- Length check at launch: if prog_len>PROG_DEPTH or conf_len>CONF_DEPTH, then err=1, no writes are issued, and the FSM returns to IDLE with busy=0.
- start while busy=1 is ignored.
- FSM states: IDLE → P_RD → P_WR → (loop) → C_RD → C_WR → (loop) → DONE.
- P_RD: present prog_addr=p, where p runs 0..N-1.
  - N = PROG_DEPTH when CLEAR_UNUSED=1, otherwise N = prog_len.
- P_WR:
  - action=LOAD_ACTION; index=p.
  - din = {16'h0, prog_data} if p<prog_len, else 32'h0.
  - mindex=0.
  - Next state: P_RD for p+1, or C_RD once p=N-1.
- N=0: the program phase is skipped entirely; the FSM goes to C_RD directly.
- C_RD: present conf_addr=c, where c runs 0..conf_len-1.
- C_WR:
  - action=conf_data[37:32]; din=conf_data[31:0].
  - mindex = conf_data[39:38] masked to MW bits; upper bits are 0 when NUM_SM<4.
  - index is held at its last value.
- An entry whose action field is 0 is consumed silently: no strobe, but the count still advances.
- conf_len=0: the FSM goes straight to DONE.
- DONE: busy=0, done=1. done stays 1 until the next launch or reset.
- Timing:
  - Each write takes 2 cycles; action is 0 in every RD cycle.
  - A full load takes 2·N + 2·conf_len + 1 cycles from launch to done=1.
- busy is 1 from the cycle after launch through the last WR cycle inclusive.
- Counters are wide enough that no wrap occurs; p and c never exceed their depth minus 1.

Test Plan:
- Auto-start: AUTO_START=1, prog_len=4, conf_len=2, CLEAR_UNUSED=1 → 32 program strobes with index 0..31 in order.
  - din = ROM words for index 0..3, then 0 for index 4..31.
  - Then 2 config strobes with ROM action/data/mindex.
  - done=1 exactly 69 cycles after reset release.
- Timing with no fill: CLEAR_UNUSED=0, start with prog_len=3, conf_len=0 → exactly 3 strobes with action=1 and index 0,1,2; done 7 cycles after start; action=0 between strobes.
- Rejected and zero-length requests:
  - prog_len=33 → err=1, zero strobes, busy never 1.
  - A following start with prog_len=0, conf_len=0 → err cleared, done=1 one cycle later.
- Config entry handling:
  - Entry 40'h C0_0000_00FF → mindex=3, action=0, so no strobe.
  - Entry 40'h 45_1234_5678 → mindex=1, action=5, din=32'h12345678.
- Start while busy and reset mid-load:
  - Pulse start during the program phase → ignored, sequence unchanged.
  - Assert reset at the 10th strobe → outputs go to reset values next cycle; the load restarts from index 0 after release.
- Re-load from DONE: start again with different lengths → full sequence repeats, done deasserts at launch.

Source files
------------

// File: rtl/pio_loader.sv
// pio_loader: boot sequencer that copies a program image and a list of
// configuration entries from two synchronous ROMs into the pio command port.
// Each write is a read cycle (ROM address presented) followed by a write
// cycle (ROM data valid, command strobed for exactly one cycle).
module pio_loader #(
  parameter int PROG_DEPTH   = 32,
  parameter int CONF_DEPTH   = 32,
  parameter int NUM_SM       = 4,
  parameter int LOAD_ACTION  = 1,
  parameter int AUTO_START   = 1,
  parameter int CLEAR_UNUSED = 1,
  localparam int PAW = $clog2(PROG_DEPTH),
  localparam int CAW = $clog2(CONF_DEPTH),
  localparam int MW  = (NUM_SM > 2) ? $clog2(NUM_SM) : 1
) (
  input  logic           clk_25mhz,
  input  logic           reset,
  input  logic           start,
  input  logic [PAW:0]   prog_len,
  input  logic [CAW:0]   conf_len,
  output logic [PAW-1:0] prog_addr,
  input  logic [15:0]    prog_data,
  output logic [CAW-1:0] conf_addr,
  input  logic [39:0]    conf_data,
  output logic [5:0]     action,
  output logic [4:0]     index,
  output logic [31:0]    din,
  output logic [1:0]     mindex,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam logic [PAW:0] PROG_DEPTH_L  = PROG_DEPTH[PAW:0];
  localparam logic [CAW:0] CONF_DEPTH_L  = CONF_DEPTH[CAW:0];
  localparam logic [PAW:0] P_ONE         = {{PAW{1'b0}}, 1'b1};
  localparam logic [CAW:0] C_ONE         = {{CAW{1'b0}}, 1'b1};
  localparam logic [5:0]   LOAD_ACTION_L = LOAD_ACTION[5:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_P_RD,
    S_P_WR,
    S_C_RD,
    S_C_WR,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [PAW-1:0] p_q, p_d;
  logic [CAW-1:0] c_q, c_d;
  logic [PAW:0]   plen_q, plen_d;
  logic [PAW:0]   n_q, n_d;
  logic [CAW:0]   clen_q, clen_d;
  logic [4:0]     index_q, index_d;
  logic           err_q, err_d;
  logic           auto_q, auto_d;

  logic           launch;
  logic           len_bad;
  logic [PAW:0]   n_launch;
  logic           p_last;
  logic           c_last;
  logic [1:0]     mindex_cfg;

  // Only MW bits of the state-machine selector are meaningful; the rest read as 0.
  generate
    if (MW >= 2) begin : g_mindex_full
      assign mindex_cfg = conf_data[39:38];
    end else begin : g_mindex_narrow
      assign mindex_cfg = {1'b0, conf_data[38]};
    end
  endgenerate

  assign launch   = ((state_q == S_IDLE) || (state_q == S_DONE)) && (start || auto_q);
  assign len_bad  = (prog_len > PROG_DEPTH_L) || (conf_len > CONF_DEPTH_L);
  // With zero-fill every slot is written, otherwise only the loaded ones.
  assign n_launch = (CLEAR_UNUSED != 0) ? PROG_DEPTH_L : prog_len;
  assign p_last   = (({1'b0, p_q} + P_ONE) == n_q);
  assign c_last   = (({1'b0, c_q} + C_ONE) == clen_q);

  // State and counter registers; reset aborts any load and re-arms auto-start.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      c_q     <= '0;
      plen_q  <= '0;
      n_q     <= '0;
      clen_q  <= '0;
      index_q <= '0;
      err_q   <= 1'b0;
      auto_q  <= (AUTO_START != 0);
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      plen_q  <= plen_d;
      n_q     <= n_d;
      clen_q  <= clen_d;
      index_q <= index_d;
      err_q   <= err_d;
      auto_q  <= auto_d;
    end
  end

  // Next-state logic: launch/length check, program loop, config loop.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    plen_d  = plen_q;
    n_d     = n_q;
    clen_d  = clen_q;
    index_d = index_q;
    err_d   = err_q;
    auto_d  = auto_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (launch) begin
          auto_d = 1'b0;
          err_d  = len_bad;
          plen_d = prog_len;
          clen_d = conf_len;
          n_d    = n_launch;
          p_d    = '0;
          c_d    = '0;
          if (len_bad) begin
            state_d = S_IDLE;
          end else if (n_launch != '0) begin
            state_d = S_P_RD;
          end else if (conf_len != '0) begin
            state_d = S_C_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_P_RD: state_d = S_P_WR;
      S_P_WR: begin
        index_d = 5'(p_q);
        if (p_last) begin
          state_d = (clen_q != '0) ? S_C_RD : S_DONE;
        end else begin
          p_d     = p_q + P_ONE[PAW-1:0];
          state_d = S_P_RD;
        end
      end
      S_C_RD: state_d = S_C_WR;
      S_C_WR: begin
        if (c_last) begin
          state_d = S_DONE;
        end else begin
          c_d     = c_q + C_ONE[CAW-1:0];
          state_d = S_C_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command port: strobe only in write cycles, data taken straight from ROM.
  always_comb begin
    action = 6'd0;
    index  = index_q;
    din    = 32'h0;
    mindex = 2'd0;
    unique case (state_q)
      S_P_WR: begin
        action = LOAD_ACTION_L;
        index  = 5'(p_q);
        din    = ({1'b0, p_q} < plen_q) ? {16'h0, prog_data} : 32'h0;
      end
      S_C_WR: begin
        action = conf_data[37:32];
        din    = conf_data[31:0];
        mindex = mindex_cfg;
      end
      default: ;
    endcase
  end

  assign prog_addr = p_q;
  assign conf_addr = c_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_pio_loader.sv
// Bench for pio_loader: instance A uses auto-start with zero-fill, instance B
// has neither. Every cycle of a load is compared against a timing model.
module tb_pio_loader;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [5:0]  plen_a = 6'd4, clen_a = 6'd2, plen_b = 6'd0, clen_b = 6'd0;
  logic [4:0]  paddr_a, paddr_b, caddr_a, caddr_b;
  logic [15:0] pdata_a, pdata_b;
  logic [39:0] cdata_a, cdata_b;
  logic [5:0]  action_a, action_b;
  logic [4:0]  index_a, index_b;
  logic [31:0] din_a, din_b;
  logic [1:0]  mindex_a, mindex_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

  logic [15:0] prog_rom [32];
  logic [39:0] conf_rom [32];

  int n_cmp = 0;
  int n_bad = 0;

  pio_loader #(.AUTO_START(1), .CLEAR_UNUSED(1)) dut_a (
    .clk_25mhz(clk), .reset(reset), .start(start_a),
    .prog_len(plen_a), .conf_len(clen_a),
    .prog_addr(paddr_a), .prog_data(pdata_a),
    .conf_addr(caddr_a), .conf_data(cdata_a),
    .action(action_a), .index(index_a), .din(din_a), .mindex(mindex_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  pio_loader #(.AUTO_START(0), .CLEAR_UNUSED(0)) dut_b (
    .clk_25mhz(clk), .reset(reset), .start(start_b),
    .prog_len(plen_b), .conf_len(clen_b),
    .prog_addr(paddr_b), .prog_data(pdata_b),
    .conf_addr(caddr_b), .conf_data(cdata_b),
    .action(action_b), .index(index_b), .din(din_b), .mindex(mindex_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  // Synchronous ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    pdata_a <= prog_rom[paddr_a];
    pdata_b <= prog_rom[paddr_b];
    cdata_a <= conf_rom[caddr_a];
    cdata_b <= conf_rom[caddr_b];
  end

  typedef struct packed {
    logic [5:0]  action;
    logic [4:0]  index;
    logic [31:0] din;
    logic [1:0]  mindex;
    logic [4:0]  paddr;
    logic [4:0]  caddr;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    int inst;
    int plen;
    int clen;
    int exp_strobes;
    int exp_cycles;
    bit exp_err;
    int pulse_at;
  } vec_t;

  function automatic obs_t get(input int inst);
    obs_t o;
    if (inst == 0) begin
      o = '{action_a, index_a, din_a, mindex_a, paddr_a, caddr_a, busy_a, done_a, err_a};
    end else begin
      o = '{action_b, index_b, din_b, mindex_b, paddr_b, caddr_b, busy_b, done_b, err_b};
    end
    return o;
  endfunction

  // Expected outputs k cycles after launch for a load of n slots / clen entries.
  function automatic void model(input int k, input int n, input int plen, input int clen,
                                output obs_t e, output obs_t m);
    int p;
    int c;
    logic [39:0] cfg;
    e = '0;
    m = '0;
    m.action = '1; m.busy = 1'b1; m.done = 1'b1; m.err = 1'b1;
    if (k <= 2 * n) begin
      e.busy = 1'b1;
      p = (k - 1) / 2;
      if (k % 2 == 0) begin
        e.action = 6'd1;
        e.index  = 5'(p);
        e.din    = (p < plen) ? {16'h0, prog_rom[p]} : 32'h0;
        m.index = '1; m.din = '1; m.mindex = '1;
      end else begin
        e.paddr = 5'(p);
        m.paddr = '1;
      end
    end else if (k <= 2 * n + 2 * clen) begin
      e.busy = 1'b1;
      c = (k - 2 * n - 1) / 2;
      if ((k - 2 * n) % 2 == 0) begin
        cfg      = conf_rom[c];
        e.action = cfg[37:32];
        e.mindex = cfg[39:38];
        m.mindex = '1;
        if (cfg[37:32] != 6'd0) begin
          e.din = cfg[31:0];
          m.din = '1;
        end
      end else begin
        e.caddr = 5'(c);
        m.caddr = '1;
      end
    end else begin
      e.done = 1'b1;
    end
  endfunction

  task automatic cmp(input string name, input obs_t got, input obs_t exp, input obs_t m);
    n_cmp++;
    if ((got & m) !== (exp & m)) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (mask %h)", name, got & m, exp & m, m);
    end
  endtask

  task automatic cmp_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic drive(input int inst, input logic st, input logic [5:0] pl, input logic [5:0] cl);
    if (inst == 0) begin
      start_a = st; plen_a = pl; clen_a = cl;
    end else begin
      start_b = st; plen_b = pl; clen_b = cl;
    end
  endtask

  task automatic launch(input int inst, input int pl, input int cl);
    @(negedge clk);
    drive(inst, 1'b1, 6'(pl), 6'(cl));
  endtask

  // Walks ncyc cycles after a launch, checking every one. Lengths are
  // scrambled after launch and start may be pulsed while busy.
  task automatic run_load(input string tag, input int inst, input int n, input int plen,
                          input int clen, input bit is_err, input int ncyc,
                          input int pulse_at, input int exp_strobes);
    int strobes;
    obs_t got, e, m;
    strobes = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      got = get(inst);
      if (is_err) begin
        e = '0; e.err = 1'b1;
        m = '0; m.action = '1; m.busy = 1'b1; m.done = 1'b1; m.err = 1'b1;
      end else begin
        model(k, n, plen, clen, e, m);
      end
      cmp($sformatf("%s cycle%0d", tag, k), got, e, m);
      if (got.action != 6'd0) strobes++;
      drive(inst, (k == pulse_at), 6'd63, 6'd63);
    end
    cmp_int($sformatf("%s strobes", tag), strobes, exp_strobes);
    $display("load %s inst=%0d prog_len=%0d conf_len=%0d strobes=%0d", tag, inst, plen, clen, strobes);
  endtask

  vec_t tbl [9];
  obs_t zero_obs, full_mask;

  initial begin
    int strobes;
    obs_t got, e, m;

    for (int i = 0; i < 32; i++) begin
      prog_rom[i] = 16'hA500 ^ 16'(i * 16'h0137);
      conf_rom[i] = 40'h0;
    end
    conf_rom[0] = 40'h45_1234_5678;
    conf_rom[1] = 40'h8A_DEAD_BEEF;
    conf_rom[2] = 40'hC0_0000_00FF;
    conf_rom[3] = 40'h01_0000_0001;

    //            inst plen clen strobes cycles err pulse
    tbl[0] = '{1,   3,   0,   3,   7,  1'b0, 0};
    tbl[1] = '{1,  33,   0,   0,   3,  1'b1, 0};
    tbl[2] = '{1,   0,   0,   0,   1,  1'b0, 0};
    tbl[3] = '{1,   2,   2,   4,   9,  1'b0, 0};
    tbl[4] = '{1,   5,   4,   8,  19,  1'b0, 3};
    tbl[5] = '{0,   1,   3,  34,  71,  1'b0, 5};
    tbl[6] = '{1,   4,  33,   0,   3,  1'b1, 0};
    tbl[7] = '{0,   0,   0,  32,  65,  1'b0, 0};
    tbl[8] = '{0,  40,   2,   0,   3,  1'b1, 0};

    zero_obs  = '0;
    full_mask = '1;

    // Reset state of both instances, then auto-start of A on release.
    repeat (3) @(negedge clk);
    cmp("reset state A", get(0), zero_obs, full_mask);
    cmp("reset state B", get(1), zero_obs, full_mask);
    reset = 1'b0;
    run_load("auto", 0, 32, 4, 2, 1'b0, 69, 0, 34);

    for (int i = 0; i < 9; i++) begin
      launch(tbl[i].inst, tbl[i].plen, tbl[i].clen);
      run_load($sformatf("v%0d", i), tbl[i].inst,
               (tbl[i].inst == 0) ? 32 : tbl[i].plen,
               tbl[i].plen, tbl[i].clen, tbl[i].exp_err,
               tbl[i].exp_cycles, tbl[i].pulse_at, tbl[i].exp_strobes);
    end

    // Reset asserted right after the 10th strobe of a load on A.
    launch(0, 6, 1);
    strobes = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      got = get(0);
      model(k, 32, 6, 1, e, m);
      cmp($sformatf("midload cycle%0d", k), got, e, m);
      if (got.action != 6'd0) strobes++;
      drive(0, 1'b0, 6'd63, 6'd63);
      if (strobes == 10) break;
    end
    cmp_int("midload strobes before reset", strobes, 10);
    reset = 1'b1;
    @(negedge clk);
    cmp("midload reset values", get(0), zero_obs, full_mask);
    drive(0, 1'b0, 6'd4, 6'd2);
    @(negedge clk);
    reset = 1'b0;
    run_load("restart", 0, 32, 4, 2, 1'b0, 69, 0, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
